// File: rtl/alu_instr_encoder.sv
// RV32I OP/OP-IMM field-set to instruction-word encoder with burst address generation.
// Optional ENCODER_NOP_PAD_EN: pad every burst with NOPs up to MAX_WORDS before completing.
module alu_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_isImm,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic              in_funcQual,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = MAX_WORDS[ADDR_W:0];
  localparam logic [6:0]      OPC_OP  = 7'b0110011;
  localparam logic [6:0]      OPC_IMM = 7'b0010011;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]     acc_cnt_q, acc_cnt_d;
  logic                err_q, err_d;

  logic        is_shift, illegal, slot_free, out_fire, in_fire, in_ready_c;
  logic [31:0] enc;

  always_comb begin
    is_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);
    if (in_isImm) begin
      if (is_shift) begin
        illegal = (in_imm[11:5] != 7'd0) || ((in_func3 == 3'b001) && in_funcQual);
        enc     = {1'b0, in_funcQual, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, OPC_IMM};
      end else begin
        illegal = in_funcQual;
        enc     = {in_imm, in_rs1, in_func3, in_rd, OPC_IMM};
      end
    end else begin
      illegal = in_funcQual && !((in_func3 == 3'b000) || (in_func3 == 3'b101));
      enc     = {1'b0, in_funcQual, 5'b0, in_rs2, in_rs1, in_func3, in_rd, OPC_OP};
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    err_d       = err_q;

    slot_free  = !out_valid_q || out_ready;
    out_fire   = out_valid_q && out_ready;
    in_ready_c = (state_q == S_RUN) && slot_free && (acc_cnt_q < MAX_CNT);
    in_fire    = in_valid && in_ready_c;

    if (out_fire) begin
      out_valid_d = 1'b0;
      word_cnt_d  = word_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          addr_d     = base_addr;
          word_cnt_d = '0;
          acc_cnt_d  = '0;
          err_d      = 1'b0;
        end
      end
      S_RUN: begin
        if (in_fire) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = enc;
            out_addr_d  = addr_q;
            addr_d      = addr_q + 1'b1;
          end
        end
        if (finish || (in_fire && (acc_cnt_q + 1'b1 == MAX_CNT)))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (slot_free) begin
`ifdef ENCODER_NOP_PAD_EN
          // Count the word still in the output register as already emitted.
          if (word_cnt_q + {{ADDR_W{1'b0}}, out_valid_q} < MAX_CNT) begin
            out_valid_d = 1'b1;
            out_instr_d = 32'h0000_0013;
            out_addr_d  = addr_q;
            addr_d      = addr_q + 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      acc_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Scoreboard bench for alu_instr_encoder: directed field sets, expected words queued at issue.
// Expectations follow ENCODER_NOP_PAD_EN when the build defines it.
module tb_alu_instr_encoder;
  localparam int AW = 8;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, finish;
  logic [AW-1:0] base_addr;
  logic          in_valid, in_ready, in_isImm;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_func3;
  logic          in_funcQual;
  logic [11:0]   in_imm;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          busy, done, err;
  logic [AW:0]   word_cnt;

  alu_instr_encoder #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(rst), .start(start), .finish(finish), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_isImm(in_isImm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3),
    .in_funcQual(in_funcQual), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc = 0;
  logic [AW-1:0] exp_addr;
  logic [31+AW:0] sb[$];
  logic [31+AW:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is checked against the oldest queued word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got instr 0x%08h addr 0x%02h expected no word", out_instr, out_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("out_instr", out_instr, mon_e[31:0]);
        chk("out_addr", 32'(out_addr), 32'(mon_e[31+AW:32]));
        $display("word addr 0x%02h instr 0x%08h", out_addr, out_instr);
      end
    end
  end

  task automatic send(input logic isimm, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic q,
                      input logic [11:0] imm, input logic legal, input logic [31:0] exp_i);
    int n;
    in_isImm = isimm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_funcQual = q; in_imm = imm; in_valid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else if (legal) begin
      sb.push_back({exp_addr, exp_i});
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    start = 1'b1; base_addr = base; exp_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done", 32'(done), 32'd1);
  endtask

  task automatic push_nops(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      sb.push_back({exp_addr, 32'h0000_0013});
      exp_addr = exp_addr + 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; finish = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_isImm = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_func3 = '0;
    in_funcQual = 1'b0; in_imm = '0; out_ready = 1'b0; exp_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Burst 1: basic encodings, illegal shift, backpressure, throughput.
    pulse_start(8'h10);
    chk("busy_run", 32'(busy), 1);
    send(0, 5'd3, 5'd1, 5'd2, 3'b000, 0, 12'h000, 1, 32'h002081B3);
    send(0, 5'd3, 5'd1, 5'd2, 3'b000, 1, 12'h000, 1, 32'h402081B3);
    send(1, 5'd5, 5'd0, 5'd0, 3'b000, 0, 12'hFFF, 1, 32'hFFF00293);
    send(1, 5'd6, 5'd7, 5'd0, 3'b101, 1, 12'h003, 1, 32'h4033D313);
    send(1, 5'd6, 5'd7, 5'd0, 3'b001, 0, 12'h020, 0, 32'h0);
    chk("err_illegal_shift", 32'(err), 1);
    chk("no_output_illegal", 32'(out_valid), 0);
    chk("word_cnt_4", 32'(word_cnt), 4);

    out_ready = 1'b0;
    send(1, 5'd4, 5'd1, 5'd0, 3'b010, 0, 12'h005, 1, 32'h0050A213);
    in_isImm = 1'b0; in_rd = 5'd8; in_rs1 = 5'd9; in_rs2 = 5'd10;
    in_func3 = 3'b100; in_funcQual = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_instr", out_valid ? out_instr : 32'hDEADBEEF, 32'h0050A213);
      chk("bp_out_addr", 32'(out_addr), 32'h14);
    end
    @(posedge clk); #1;
    sb.push_back({exp_addr, 32'h00A4C433});
    exp_addr = exp_addr + 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    c0 = cyc;
    send(0, 5'd9, 5'd10, 5'd11, 3'b111, 0, 12'h000, 1, 32'h00B574B3);
    send(1, 5'd1, 5'd2, 5'd0, 3'b110, 0, 12'h0F0, 1, 32'h0F016093);
    send(0, 5'd12, 5'd13, 5'd14, 3'b101, 1, 12'h000, 1, 32'h40E6D633);
    chk("one_word_per_cycle", 32'(cyc - c0), 3);
`ifdef ENCODER_NOP_PAD_EN
    push_nops(7);
`endif
    pulse_finish();
    wait_done();
`ifdef ENCODER_NOP_PAD_EN
    chk("b1_word_cnt", 32'(word_cnt), 16);
`else
    chk("b1_word_cnt", 32'(word_cnt), 9);
`endif

    // Burst 2: MAX_WORDS limit with address wrap.
    pulse_start(8'hF8);
    for (int i = 0; i < MW; i++)
      send(1, 5'(i + 1), 5'd0, 5'd0, 3'b000, 0, 12'(i), 1,
           {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011});
    in_isImm = 1'b1; in_func3 = 3'b000; in_funcQual = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("limit_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done();
    chk("b2_word_cnt", 32'(word_cnt), 16);
    chk("b2_busy", 32'(busy), 0);

    // Burst 3: finish coinciding with the third accepted word.
    pulse_start(8'h40);
    send(0, 5'd1, 5'd2, 5'd3, 3'b100, 0, 12'h000, 1, 32'h003140B3);
    send(1, 5'd2, 5'd3, 5'd0, 3'b001, 0, 12'h01F, 1, 32'h01F19113);
    finish = 1'b1;
    send(0, 5'd4, 5'd5, 5'd6, 3'b010, 0, 12'h000, 1, 32'h0062A233);
    finish = 1'b0;
`ifdef ENCODER_NOP_PAD_EN
    push_nops(13);
`endif
    wait_done();
`ifdef ENCODER_NOP_PAD_EN
    chk("b3_word_cnt", 32'(word_cnt), 16);
`else
    chk("b3_word_cnt", 32'(word_cnt), 3);
`endif
    chk("sb_drained", 32'(sb.size()), 0);

    // Burst 4: illegal OP qualifier, then asynchronous reset with a word pending.
    pulse_start(8'h20);
    send(0, 5'd1, 5'd2, 5'd3, 3'b111, 1, 12'h000, 0, 32'h0);
    out_ready = 1'b0;
    send(0, 5'd3, 5'd1, 5'd2, 3'b000, 0, 12'h000, 1, 32'h002081B3);
    chk("pre_rst_err", 32'(err), 1);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_instr", out_instr, 0);
    chk("arst_out_addr", 32'(out_addr), 0);
    chk("arst_word_cnt", 32'(word_cnt), 0);
    chk("arst_busy_done_err", {29'd0, busy, done, err}, 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
